hwag_capture_sync: RTL and testbench
====================================

Name: hwag_capture_sync

Overview:
- Sequencer that sits after the filtered, edge-selected crank-capture path. It consumes the single-cycle selected-edge pulse.
- Measures the tooth period in clock cycles and detects the missing-tooth gap.
- Runs the synchronisation state machine that produces the tooth index for the angle generator. Also flags stalls and tooth-count errors.

Parameters:
- PCNT_WIDTH, 24, width of the period counter and period outputs.
- TOOTH_WIDTH, 6, width of the tooth index and tooth_last.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ena  in  1  global enable; 0 freezes all state, and edge_in is ignored.
- edge_in  in  1  one-cycle selected-edge pulse from the capture path.
- tooth_last  in  TOOTH_WIDTH  edges per revolution minus 1 (60-2 wheel = 57); quasi-static.
- period  out  PCNT_WIDTH  most recent tooth period, in cycles.
- period_prev  out  PCNT_WIDTH  period before that.
- period_valid  out  1  one-cycle pulse when period is updated with a valid measurement.
- tooth_cnt  out  TOOTH_WIDTH  tooth index; 0 = first edge after the gap.
- gap  out  1  one-cycle pulse, gap edge detected.
- synced  out  1  level, position locked.
- sync_err  out  1  one-cycle pulse, tooth count mismatch.
- stall  out  1  one-cycle pulse, period counter saturated.

Behaviour:
- Reset: all outputs, cnt and tooth_cnt are 0; state is IDLE. Reset has priority over everything.
- Registered outputs; every pulse asserts the cycle after the edge_in cycle.
- Period counter cnt:
  - On an ena cycle without edge_in: cnt <= cnt+1, saturating at 2^PCNT_WIDTH-1.
  - On an ena cycle with edge_in: measured value m = cnt+1 (saturating), and cnt <= 0. Edges at cycles t and t+N give m = N.
- gap_cond = m > period + (period>>1). Compute at PCNT_WIDTH+1 bits, no overflow. Evaluated only when a previous period is valid.
- On every accepted edge outside IDLE: period_prev <= period, period <= m.
- States:
  - IDLE: edge -> FIRST. No period update and no period_valid (m is meaningless).
  - FIRST: edge -> SEARCH. period = m, period_valid = 1, no gap evaluation.
  - SEARCH: each edge gives period_valid. gap_cond -> VERIFY with tooth_cnt <= 0 and gap pulse. Otherwise stay.
  - VERIFY: on a non-gap edge:
    - tooth_cnt < tooth_last: tooth_cnt += 1.
    - tooth_cnt == tooth_last (expected gap missing): sync_err, -> SEARCH, tooth_cnt <= 0.
  - VERIFY: on a gap edge:
    - tooth_cnt == tooth_last: -> SYNC, synced <= 1, tooth_cnt <= 0, gap pulse.
    - Else: sync_err, tooth_cnt <= 0, stay VERIFY (this gap is the new reference), gap pulse.
  - SYNC: same counting rules as VERIFY; gap pulse on a correct gap.
  - SYNC, any error: sync_err, synced <= 0.
    - Missing gap -> SEARCH.
    - Early gap -> VERIFY with tooth_cnt <= 0.
- Stall: cnt reaches saturation with no edge (transition into the saturated value).
  - Effects: stall pulse once, state -> IDLE, synced <= 0, tooth_cnt <= 0.
  - period and period_prev hold their values.
  - cnt stays saturated until the next edge, which is then handled as the IDLE edge.
- Edge on the same cycle cnt would saturate: the edge wins, and m is the saturated value. A gap is evaluated normally; no stall.
- ena=0: all registers hold, and pulses deassert.
- rst mid-sync: the next cycle reads IDLE and zero outputs; the first following edge is not measured.

Test Plan:
- Edges every 100 cycles, tooth_last=57:
  - First edge: no period_valid.
  - Second edge: period=100, period_valid.
  - Never gap; stays SEARCH; synced=0.
- 60-2 wheel: 57 gaps of 100 then one of 300, tooth_last=57:
  - First 300 gives gap, VERIFY, tooth_cnt=0.
  - 57 edges later tooth_cnt=57.
  - Next 300 gives synced=1 and tooth_cnt=0.
  - Next edge gives tooth_cnt=1.
- Synced, then the gap is omitted (58 normal edges): the 58th non-gap edge at tooth_cnt=57 gives sync_err, synced=0, SEARCH.
- Synced, then a gap inserted at tooth_cnt=30: sync_err, synced=0, VERIFY, tooth_cnt=0; the following correct revolution re-locks.
- PCNT_WIDTH=8, edges stop: stall pulse exactly once, 255 cycles after the last edge, and state IDLE. The next edge gives no period_valid; the one after gives the correct period.
- ena low for 50 cycles mid-sync with edge_in pulsed: there are no changes. rst while synced gives all outputs 0 one cycle later.

Source files
------------

// File: rtl/hwag_capture_sync_if.sv
// Crank-sync bus: edge/enable/config inputs to the sequencer and its registered status outputs.
// The master side drives edges; the slave side is the sequencer.
interface hwag_capture_sync_if #(
   parameter int unsigned PCNT_WIDTH  = 24,
   parameter int unsigned TOOTH_WIDTH = 6
);
   logic                   ena;
   logic                   edge_in;
   logic [TOOTH_WIDTH-1:0] tooth_last;
   logic [PCNT_WIDTH-1:0]  period;
   logic [PCNT_WIDTH-1:0]  period_prev;
   logic                   period_valid;
   logic [TOOTH_WIDTH-1:0] tooth_cnt;
   logic                   gap;
   logic                   synced;
   logic                   sync_err;
   logic                   stall;

   modport master (
      output ena, edge_in, tooth_last,
      input  period, period_prev, period_valid, tooth_cnt, gap, synced, sync_err, stall
   );

   modport slave (
      input  ena, edge_in, tooth_last,
      output period, period_prev, period_valid, tooth_cnt, gap, synced, sync_err, stall
   );
endinterface

// File: rtl/hwag_capture_sync.sv
// Crank tooth-period measurement, missing-tooth gap detection and sync state machine
// producing the tooth index for the angle generator.
module hwag_capture_sync #(
   parameter int unsigned PCNT_WIDTH  = 24,
   parameter int unsigned TOOTH_WIDTH = 6
) (
   input logic               clk,
   input logic               rst,
   hwag_capture_sync_if.slave bus
);

   typedef enum logic [2:0] {StIdle, StFirst, StSearch, StVerify, StSync} state_e;

   localparam logic [PCNT_WIDTH-1:0] CntMax = '1;

   state_e                 state_q, state_d;
   logic [PCNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [PCNT_WIDTH-1:0]  period_q, period_d;
   logic [PCNT_WIDTH-1:0]  period_prev_q, period_prev_d;
   logic [TOOTH_WIDTH-1:0] tooth_q, tooth_d;
   logic                   period_valid_q, period_valid_d;
   logic                   gap_q, gap_d;
   logic                   synced_q, synced_d;
   logic                   sync_err_q, sync_err_d;
   logic                   stall_q, stall_d;

   logic [PCNT_WIDTH-1:0]  meas;
   logic                   gap_cond;

   // Saturating increment doubles as the measured period on an edge cycle.
   assign meas     = (cnt_q == CntMax) ? CntMax : cnt_q + 1'b1;
   assign gap_cond = {1'b0, meas} > ({1'b0, period_q} + {1'b0, (period_q >> 1)});

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      period_d       = period_q;
      period_prev_d  = period_prev_q;
      tooth_d        = tooth_q;
      synced_d       = synced_q;
      period_valid_d = 1'b0;
      gap_d          = 1'b0;
      sync_err_d     = 1'b0;
      stall_d        = 1'b0;

      if (bus.ena) begin
         if (bus.edge_in) begin
            cnt_d = '0;
            if (state_q != StIdle) begin
               period_prev_d  = period_q;
               period_d       = meas;
               period_valid_d = 1'b1;
            end
            unique case (state_q)
               StIdle:  state_d = StFirst;
               StFirst: state_d = StSearch;
               StSearch: begin
                  if (gap_cond) begin
                     state_d = StVerify;
                     tooth_d = '0;
                     gap_d   = 1'b1;
                  end
               end
               StVerify, StSync: begin
                  if (gap_cond) begin
                     gap_d   = 1'b1;
                     tooth_d = '0;
                     if (tooth_q == bus.tooth_last) begin
                        state_d  = StSync;
                        synced_d = 1'b1;
                     end else begin
                        // Early gap becomes the new reference for another verify pass.
                        state_d    = StVerify;
                        synced_d   = 1'b0;
                        sync_err_d = 1'b1;
                     end
                  end else if (tooth_q < bus.tooth_last) begin
                     tooth_d = tooth_q + 1'b1;
                  end else begin
                     state_d    = StSearch;
                     synced_d   = 1'b0;
                     sync_err_d = 1'b1;
                     tooth_d    = '0;
                  end
               end
               default: state_d = StIdle;
            endcase
         end else begin
            cnt_d = meas;
            // Stall fires only on the transition into saturation, so it pulses once.
            if (cnt_q != CntMax && meas == CntMax) begin
               stall_d  = 1'b1;
               state_d  = StIdle;
               synced_d = 1'b0;
               tooth_d  = '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StIdle;
         cnt_q          <= '0;
         period_q       <= '0;
         period_prev_q  <= '0;
         tooth_q        <= '0;
         period_valid_q <= 1'b0;
         gap_q          <= 1'b0;
         synced_q       <= 1'b0;
         sync_err_q     <= 1'b0;
         stall_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         period_q       <= period_d;
         period_prev_q  <= period_prev_d;
         tooth_q        <= tooth_d;
         period_valid_q <= period_valid_d;
         gap_q          <= gap_d;
         synced_q       <= synced_d;
         sync_err_q     <= sync_err_d;
         stall_q        <= stall_d;
      end
   end

   assign bus.period       = period_q;
   assign bus.period_prev  = period_prev_q;
   assign bus.period_valid = period_valid_q;
   assign bus.tooth_cnt    = tooth_q;
   assign bus.gap          = gap_q;
   assign bus.synced       = synced_q;
   assign bus.sync_err     = sync_err_q;
   assign bus.stall        = stall_q;

endmodule

// File: tb/tb_hwag_capture_sync.sv
// Bench for hwag_capture_sync: a 24-bit instance runs the 60-2 sync scenarios through an
// edge scoreboard; an 8-bit instance exercises stall and saturation boundaries.
module tb_hwag_capture_sync;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   hwag_capture_sync_if #(.PCNT_WIDTH(24), .TOOTH_WIDTH(6)) bus ();
   hwag_capture_sync_if #(.PCNT_WIDTH(8), .TOOTH_WIDTH(6)) bus8 ();

   hwag_capture_sync #(.PCNT_WIDTH(24), .TOOTH_WIDTH(6)) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   hwag_capture_sync #(.PCNT_WIDTH(8), .TOOTH_WIDTH(6)) u_dut8 (
      .clk(clk),
      .rst(rst),
      .bus(bus8)
   );

   typedef struct {
      int          cyc;
      logic [23:0] period;
      logic [23:0] prev;
      logic        pv;
      logic [5:0]  tooth;
      logic        gap;
      logic        synced;
      logic        serr;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   logic [58:0] mon_act, mon_exp;

   function automatic exp_t mk(input int p, input int pp, input int pv, input int t,
                               input int g, input int s, input int e);
      exp_t r;
      r.cyc    = 0;
      r.period = 24'(p);
      r.prev   = 24'(pp);
      r.pv     = (pv != 0);
      r.tooth  = 6'(t);
      r.gap    = (g != 0);
      r.synced = (s != 0);
      r.serr   = (e != 0);
      return r;
   endfunction

   function automatic logic [58:0] outs_main();
      return {bus.period, bus.period_prev, bus.period_valid, bus.tooth_cnt, bus.gap,
              bus.synced, bus.sync_err, bus.stall};
   endfunction

   function automatic logic [26:0] outs8();
      return {bus8.period, bus8.period_prev, bus8.period_valid, bus8.tooth_cnt, bus8.gap,
              bus8.synced, bus8.sync_err, bus8.stall};
   endfunction

   // Scoreboard: each edge's expectation is compared on the cycle its outputs register.
   always @(negedge clk) begin
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
         mon_e   = sb.pop_front();
         mon_act = outs_main();
         mon_exp = {mon_e.period, mon_e.prev, mon_e.pv, mon_e.tooth, mon_e.gap, mon_e.synced,
                    mon_e.serr, 1'b0};
         checks++;
         if (mon_e.cyc != cyc || mon_act !== mon_exp) begin
            failures++;
            $display("FAIL edge@%0d (at %0d): got per=%0d prev=%0d pv=%b tooth=%0d gap=%b syn=%b err=%b stall=%b want per=%0d prev=%0d pv=%b tooth=%0d gap=%b syn=%b err=%b stall=0",
                     mon_e.cyc, cyc, bus.period, bus.period_prev, bus.period_valid,
                     bus.tooth_cnt, bus.gap, bus.synced, bus.sync_err, bus.stall,
                     mon_e.period, mon_e.prev, mon_e.pv, mon_e.tooth, mon_e.gap,
                     mon_e.synced, mon_e.serr);
         end
      end
   end

   task automatic pulse_after(input int n, input exp_t e);
      repeat (n - 1) @(negedge clk);
      bus.edge_in = 1'b1;
      e.cyc = cyc + 1;
      sb.push_back(e);
      @(negedge clk);
      bus.edge_in = 1'b0;
   endtask

   task automatic pulse8_after(input int n);
      repeat (n - 1) @(negedge clk);
      bus8.edge_in = 1'b1;
      @(negedge clk);
      bus8.edge_in = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (outs_main() !== 59'd0) begin
         failures++;
         $display("FAIL reset_main: got %h want 0", outs_main());
      end
      checks++;
      if (outs8() !== 27'd0) begin
         failures++;
         $display("FAIL reset_w8: got %h want 0", outs8());
      end
      rst = 1'b0;
   endtask

   task automatic test_stall();
      int stall_cnt = 0;
      int stall_at  = -1;
      pulse8_after(50);
      pulse8_after(100);
      pulse8_after(100);
      checks++;
      if (bus8.period !== 8'd100 || bus8.period_prev !== 8'd100 || bus8.period_valid !== 1'b1) begin
         failures++;
         $display("FAIL stall_pre: got per=%0d prev=%0d pv=%b want 100 100 1",
                  bus8.period, bus8.period_prev, bus8.period_valid);
      end
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk);
         if (bus8.stall === 1'b1) begin
            stall_cnt++;
            if (stall_at < 0) stall_at = k;
         end
      end
      checks++;
      if (stall_cnt != 1 || stall_at != 255) begin
         failures++;
         $display("FAIL stall_pulse: got count=%0d at=%0d want count=1 at=255", stall_cnt, stall_at);
      end
      checks++;
      if (bus8.period !== 8'd100 || bus8.period_prev !== 8'd100 || bus8.synced !== 1'b0 ||
          bus8.tooth_cnt !== 6'd0) begin
         failures++;
         $display("FAIL stall_hold: got per=%0d prev=%0d syn=%b tooth=%0d want 100 100 0 0",
                  bus8.period, bus8.period_prev, bus8.synced, bus8.tooth_cnt);
      end
      pulse8_after(10);
      checks++;
      if (bus8.period_valid !== 1'b0 || bus8.period !== 8'd100) begin
         failures++;
         $display("FAIL stall_idle_edge: got pv=%b per=%0d want pv=0 per=100",
                  bus8.period_valid, bus8.period);
      end
      pulse8_after(100);
      checks++;
      if (bus8.period_valid !== 1'b1 || bus8.period !== 8'd100 || bus8.period_prev !== 8'd100) begin
         failures++;
         $display("FAIL stall_first_edge: got pv=%b per=%0d prev=%0d want 1 100 100",
                  bus8.period_valid, bus8.period, bus8.period_prev);
      end
      pulse8_after(255);
      checks++;
      if (bus8.period !== 8'd255 || bus8.gap !== 1'b1 || bus8.stall !== 1'b0 ||
          bus8.period_valid !== 1'b1) begin
         failures++;
         $display("FAIL sat_edge: got per=%0d gap=%b stall=%b pv=%b want 255 1 0 1",
                  bus8.period, bus8.gap, bus8.stall, bus8.period_valid);
      end
   endtask

   task automatic test_search();
      pulse_after(100, mk(0, 0, 0, 0, 0, 0, 0));
      pulse_after(100, mk(100, 0, 1, 0, 0, 0, 0));
      for (int i = 0; i < 9; i++) pulse_after(100, mk(100, 100, 1, 0, 0, 0, 0));
   endtask

   task automatic do_lock(input bit first_gap);
      if (first_gap) pulse_after(300, mk(300, 100, 1, 0, 1, 0, 0));
      for (int i = 1; i <= 57; i++) pulse_after(100, mk(100, (i == 1) ? 300 : 100, 1, i, 0, 0, 0));
      pulse_after(300, mk(300, 100, 1, 0, 1, 1, 0));
   endtask

   task automatic test_lock();
      do_lock(1'b1);
      pulse_after(100, mk(100, 300, 1, 1, 0, 1, 0));
   endtask

   task automatic test_missing();
      for (int i = 2; i <= 57; i++) pulse_after(100, mk(100, 100, 1, i, 0, 1, 0));
      pulse_after(100, mk(100, 100, 1, 0, 0, 0, 1));
      pulse_after(100, mk(100, 100, 1, 0, 0, 0, 0));
      do_lock(1'b1);
   endtask

   task automatic test_early();
      for (int i = 1; i <= 30; i++) pulse_after(100, mk(100, (i == 1) ? 300 : 100, 1, i, 0, 1, 0));
      pulse_after(300, mk(300, 100, 1, 0, 1, 0, 1));
      do_lock(1'b0);
   endtask

   task automatic test_freeze();
      logic [58:0] snap;
      pulse_after(100, mk(100, 300, 1, 1, 0, 1, 0));
      repeat (20) @(negedge clk);
      bus.ena = 1'b0;
      snap = outs_main();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         checks++;
         if (outs_main() !== snap) begin
            failures++;
            $display("FAIL freeze[%0d]: got %h want %h", i, outs_main(), snap);
         end
         bus.edge_in = (i % 10 == 3) && (i < 49);
      end
      bus.edge_in = 1'b0;
      bus.ena = 1'b1;
      // 20 active cycles before the freeze plus 80 after it make a 100-cycle tooth.
      pulse_after(80, mk(100, 100, 1, 2, 0, 1, 0));
   endtask

   task automatic test_reset_mid();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (outs_main() !== 59'd0) begin
         failures++;
         $display("FAIL reset_mid: got %h want 0", outs_main());
      end
      rst = 1'b0;
      pulse_after(100, mk(0, 0, 0, 0, 0, 0, 0));
      pulse_after(100, mk(100, 0, 1, 0, 0, 0, 0));
   endtask

   initial begin
      bus.ena = 1'b1;
      bus.edge_in = 1'b0;
      bus.tooth_last = 6'd57;
      bus8.ena = 1'b1;
      bus8.edge_in = 1'b0;
      bus8.tooth_last = 6'd57;
      @(negedge clk);
      test_reset();
      test_stall();
      test_search();
      test_lock();
      test_missing();
      test_early();
      test_freeze();
      test_reset_mid();
      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
